// File: rtl/thunderbolt_tsip_parser.sv
// Thunderbolt TSIP primary timing packet parser: de-stuffs the DLE-framed byte stream
// and commits the UTC date/time fields only when a complete, well-formed packet ends.
module thunderbolt_tsip_parser #(
    parameter logic [7:0] PKT_ID      = 8'h8F,
    parameter logic [7:0] PKT_SUBCODE = 8'hAB,
    parameter int         PAYLOAD_LEN = 17
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic [7:0] o_thunder_year_h,
    output logic [7:0] o_thunder_year_l,
    output logic [7:0] o_thunder_month,
    output logic [7:0] o_thunder_day,
    output logic [7:0] o_thunder_hour,
    output logic [7:0] o_thunder_minutes,
    output logic [7:0] o_thunder_seconds,
    output logic       o_update,
    output logic       o_frame_err,
    output logic [2:0] o_dbg_state
);
    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;
    localparam int IW = $clog2(PAYLOAD_LEN + 1);
    localparam logic [IW-1:0] LEN_W    = IW'(PAYLOAD_LEN);
    localparam logic [IW-1:0] CAP_BASE = IW'(PAYLOAD_LEN - 7);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_GET_ID      = 3'd1,
        S_PAYLOAD     = 3'd2,
        S_PAYLOAD_DLE = 3'd3,
        S_SKIP        = 3'd4,
        S_SKIP_DLE    = 3'd5
    } state_t;

    // Shadow/output slot order: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year_h, 6 year_l.
    logic [1:0]      r_rst_sync;
    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [6:0][7:0] r_shadow;
    logic [6:0][7:0] r_out;
    logic            r_update;
    logic            r_frame_err;

    state_t          w_state_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [6:0][7:0] w_shadow_nxt;
    logic            w_commit;
    logic            w_err;
    logic            w_store;
    logic            w_active;
    logic [2:0]      w_cap_sel;

    assign w_active  = r_rst_sync[1];
    assign w_cap_sel = 3'(r_idx - CAP_BASE);

    function automatic state_t id_next(input logic [7:0] b);
        if (b == PKT_ID)
            return S_PAYLOAD;
        else if ((b == DLE) || (b == ETX))
            return S_IDLE;
        else
            return S_SKIP;
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_shadow_nxt = r_shadow;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_store      = 1'b0;
        if (w_active && i_rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_data == DLE) w_state_nxt = S_GET_ID;
                end
                S_GET_ID: begin
                    w_state_nxt = id_next(i_rx_data);
                    w_idx_nxt   = '0;
                end
                S_PAYLOAD: begin
                    if (i_rx_data == DLE) w_state_nxt = S_PAYLOAD_DLE;
                    else                  w_store     = 1'b1;
                end
                S_PAYLOAD_DLE: begin
                    if (i_rx_data == DLE) begin
                        w_store = 1'b1;
                    end else if (i_rx_data == ETX) begin
                        w_state_nxt = S_IDLE;
                        if (r_idx == LEN_W) w_commit = 1'b1;
                        else                w_err    = 1'b1;
                    end else begin
                        // Lone DLE followed by a non-framing byte: sender restarted mid-packet.
                        w_err       = 1'b1;
                        w_state_nxt = id_next(i_rx_data);
                        w_idx_nxt   = '0;
                    end
                end
                S_SKIP: begin
                    if (i_rx_data == DLE) w_state_nxt = S_SKIP_DLE;
                end
                S_SKIP_DLE: begin
                    if (i_rx_data == DLE) begin
                        w_state_nxt = S_SKIP;
                    end else if (i_rx_data == ETX) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = id_next(i_rx_data);
                        w_idx_nxt   = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // One de-stuffed payload byte (always i_rx_data, a stuffed pair carries DLE itself).
        if (w_store) begin
            if (r_idx >= LEN_W) begin
                w_err       = 1'b1;
                w_state_nxt = S_SKIP;
            end else if ((r_idx == '0) && (i_rx_data != PKT_SUBCODE)) begin
                w_state_nxt = S_SKIP;
            end else begin
                if (r_idx >= CAP_BASE) w_shadow_nxt[w_cap_sel] = i_rx_data;
                w_idx_nxt   = r_idx + 1'b1;
                w_state_nxt = S_PAYLOAD;
            end
        end
    end

    // Reset asserts asynchronously; its release is re-timed so the parser starts cleanly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync  <= 2'b00;
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_out       <= '0;
            r_update    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rst_sync  <= {r_rst_sync[0], 1'b1};
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_shadow    <= w_shadow_nxt;
            if (w_commit) r_out <= r_shadow;
            r_update    <= w_commit;
            r_frame_err <= w_err;
        end
    end

    assign o_thunder_seconds = r_out[0];
    assign o_thunder_minutes = r_out[1];
    assign o_thunder_hour    = r_out[2];
    assign o_thunder_day     = r_out[3];
    assign o_thunder_month   = r_out[4];
    assign o_thunder_year_h  = r_out[5];
    assign o_thunder_year_l  = r_out[6];
    assign o_update          = r_update;
    assign o_frame_err       = r_frame_err;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_thunderbolt_tsip_parser.sv
// Directed and randomized packet-level bench for the TSIP timing packet parser; expectations
// come from whole-packet rules (ID, subcode, de-stuffed length) and a scoreboard queue.
module tb_thunderbolt_tsip_parser;
    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;
    localparam logic [7:0] PKT_ID = 8'h8F;
    localparam logic [7:0] PKT_SUB = 8'hAB;
    localparam int PLEN = 17;

    typedef logic [7:0] byte_q_t[$];

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] o_year_h, o_year_l, o_month, o_day, o_hour, o_min, o_sec;
    logic       o_update, o_frame_err;
    logic [2:0] o_dbg_state;

    thunderbolt_tsip_parser dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_thunder_year_h(o_year_h), .o_thunder_year_l(o_year_l), .o_thunder_month(o_month),
        .o_thunder_day(o_day), .o_thunder_hour(o_hour), .o_thunder_minutes(o_min),
        .o_thunder_seconds(o_sec), .o_update(o_update), .o_frame_err(o_frame_err),
        .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    // Time vector layout: [7:0] sec, min, hour, day, month, year_h, [55:48] year_l.
    logic [55:0] w_time;
    assign w_time = {o_year_l, o_year_h, o_month, o_day, o_hour, o_min, o_sec};

    int          n_checks = 0;
    int          n_fail = 0;
    int          upd_cnt = 0;
    int          err_cnt = 0;
    int          g_max_gap = 0;
    logic [55:0] model_time = '0;
    logic [55:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every update pulse must match the oldest expected commit.
    always @(negedge i_clk) begin
        if (o_update || o_frame_err)
            chk("pulse_exclusive", {62'd0, o_update, o_frame_err} != 64'd3, 64'd1);
        if (o_update) begin
            upd_cnt++;
            chk("update_fields", {8'h00, w_time}, (exp_q.size() > 0) ? {8'h00, exp_q.pop_front()} : 64'hx);
        end
        if (o_frame_err) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic byte_q_t good_payload(input logic [55:0] t, input bit dle_bias);
        byte_q_t q;
        q.push_back(PKT_SUB);
        for (int i = 1; i < 10; i++)
            q.push_back((dle_bias && ($urandom_range(0, 1) == 1)) ? DLE : 8'($urandom_range(0, 255)));
        for (int k = 0; k < 7; k++) q.push_back(t[8*k +: 8]);
        return q;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int gap;
        gap = (g_max_gap > 0) ? $urandom_range(0, g_max_gap) : 0;
        repeat (gap) @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_packet(input logic [7:0] id, input byte_q_t p);
        bit accepted, good, short_err, long_err;
        int before_u, before_e;
        before_u  = upd_cnt;
        before_e  = err_cnt;
        accepted  = (id == PKT_ID) && (p.size() > 0) && (p[0] == PKT_SUB);
        good      = accepted && (p.size() == PLEN);
        short_err = accepted && (p.size() < PLEN);
        long_err  = accepted && (p.size() > PLEN);
        if (good) begin
            model_time = {p[16], p[15], p[14], p[13], p[12], p[11], p[10]};
            exp_q.push_back(model_time);
        end
        send_byte(DLE);
        send_byte(id);
        foreach (p[i]) begin
            send_byte(p[i]);
            if (p[i] == DLE) send_byte(DLE);
        end
        send_byte(DLE);
        send_byte(ETX);
        chk("update_after_etx", o_update, good);
        chk("err_after_etx", o_frame_err, short_err);
        repeat (2) @(negedge i_clk);
        chk("update_count", upd_cnt - before_u, good);
        chk("err_count", err_cnt - before_e, short_err || long_err);
        chk("fields_hold", w_time, model_time);
        chk("exp_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        byte_q_t q;
        logic [7:0] id;
        int before_u, before_e;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("reset_fields", w_time, 56'h0);
        chk("reset_pulses", {o_update, o_frame_err}, 2'b00);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        // 2024-03-15 12:34:56, back-to-back bytes
        q = good_payload(56'hE8_07_03_0F_0C_22_38, 1'b0);
        send_packet(PKT_ID, q);
        chk("req031_year_h", o_year_h, 8'h07);
        chk("req031_sec", o_sec, 8'h38);

        // Seconds = 0x10 must be de-stuffed
        q = good_payload(56'hE8_07_03_0F_0C_22_10, 1'b0);
        send_packet(PKT_ID, q);
        chk("req032_sec", o_sec, 8'h10);

        // Wrong subcode ignored, then DLE-rich TOW commits
        q = good_payload(56'hE9_07_0C_1F_17_3B_3B, 1'b0);
        q[0] = 8'hAC;
        send_packet(PKT_ID, q);
        q = good_payload(56'hE9_07_0C_1F_17_3B_3B, 1'b1);
        q[1] = DLE;
        q[4] = DLE;
        send_packet(PKT_ID, q);

        // Truncated to 12 payload bytes
        q = good_payload(56'h11_22_33_44_55_66_77, 1'b0);
        while (q.size() > 12) void'(q.pop_back());
        send_packet(PKT_ID, q);

        // Lone DLE followed by a new ID mid-packet: error, then restarted packet commits
        before_u = upd_cnt;
        before_e = err_cnt;
        q = good_payload(56'h01_02_03_04_05_06_07, 1'b0);
        for (int i = 1; i < 10; i++) if (q[i] == DLE) q[i] = 8'h00;
        model_time = 56'h01_02_03_04_05_06_07;
        exp_q.push_back(model_time);
        send_byte(DLE); send_byte(PKT_ID); send_byte(PKT_SUB); send_byte(DLE); send_byte(PKT_ID);
        foreach (q[i]) send_byte(q[i]);
        send_byte(DLE); send_byte(ETX);
        chk("restart_update", o_update, 1'b1);
        repeat (2) @(negedge i_clk);
        chk("restart_err_count", err_cnt - before_e, 1);
        chk("restart_upd_count", upd_cnt - before_u, 1);

        // Reset after 9 payload bytes; tail of that packet afterwards must not commit
        q = {PKT_SUB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h00, 8'h38, 8'h22, 8'h0C, 8'h0F, 8'h03, 8'h07, 8'hE8};
        send_byte(DLE); send_byte(PKT_ID);
        for (int i = 0; i < 9; i++) send_byte(q[i]);
        #1 i_rst_n = 1'b0;
        #1;
        chk("midreset_fields", w_time, 56'h0);
        chk("midreset_pulses", {o_update, o_frame_err}, 2'b00);
        model_time = '0;
        repeat (3) @(negedge i_clk);
        chk("midreset_hold", w_time, 56'h0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        before_u = upd_cnt;
        before_e = err_cnt;
        for (int i = 9; i < PLEN; i++) send_byte(q[i]);
        send_byte(DLE); send_byte(ETX);
        repeat (2) @(negedge i_clk);
        chk("stale_tail_upd", upd_cnt - before_u, 0);
        chk("stale_tail_err", err_cnt - before_e, 0);
        send_packet(PKT_ID, q);
        chk("post_reset_month", o_month, 8'h03);

        // Same packet with idle gaps of 0..5 cycles
        g_max_gap = 5;
        q = good_payload(56'hE8_07_03_0F_0C_22_38, 1'b1);
        send_packet(PKT_ID, q);

        // Randomized mix of good, foreign, short and overlong packets
        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [55:0] t;
            kind = $urandom_range(0, 9);
            t    = 56'({$urandom(), $urandom()});
            id   = PKT_ID;
            q    = good_payload(t, kind == 9);
            case (kind)
                5: begin
                    id = 8'($urandom_range(0, 255));
                    while (id == PKT_ID || id == DLE || id == ETX) id = 8'($urandom_range(0, 255));
                end
                6: begin
                    q[0] = 8'($urandom_range(0, 255));
                    while (q[0] == PKT_SUB) q[0] = 8'($urandom_range(0, 255));
                end
                7: begin
                    int len;
                    len = $urandom_range(1, PLEN - 1);
                    while (q.size() > len) void'(q.pop_back());
                end
                8: repeat ($urandom_range(1, 3)) q.push_back(8'($urandom_range(0, 255)));
                default: ;
            endcase
            send_packet(id, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/thunderbolt_tsip_parser.md
THUNDERBOLT_TSIP_PARSER -- requirements
Module: thunderbolt_tsip_parser

Interface
REQ-001 Parameter: PKT_ID, 8'h8F, TSIP packet ID accepted.
REQ-002 Parameter: PKT_SUBCODE, 8'hAB, subcode accepted (primary timing packet).
REQ-003 Parameter: PAYLOAD_LEN, 17, number of unstuffed bytes after the ID, subcode included.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  system clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
REQ-008 i_rx_data  in  8  byte from Thunderbolt UART receiver.
REQ-009 o_thunder_year_h, o_thunder_year_l, o_thunder_month, o_thunder_day, o_thunder_hour, o_thunder_minutes, o_thunder_seconds  out  8 each  registered UTC fields of last good packet.
REQ-010 o_update  out  1  one-cycle pulse, time outputs just committed.
REQ-011 o_frame_err  out  1  one-cycle pulse, malformed or overlong accepted packet.

Function
REQ-012 The block SHALL act only on cycles with i_rx_valid=1; all state holds otherwise.
REQ-013 Framing SHALL be DLE=8'h10, ETX=8'h03; packet = DLE, ID, stuffed payload, DLE, ETX; payload 8'h10 is sent as 10 10.
REQ-014 States SHALL be IDLE, GET_ID, PAYLOAD, PAYLOAD_DLE, SKIP, SKIP_DLE.
REQ-015 IDLE: DLE -> GET_ID; any other byte -> IDLE.
REQ-016 GET_ID: PKT_ID -> PAYLOAD, byte index cleared to 0; DLE or ETX -> IDLE; any other ID -> SKIP.
REQ-017 PAYLOAD: DLE -> PAYLOAD_DLE; other byte -> store at index, index+1.
REQ-018 PAYLOAD_DLE: DLE -> store 8'h10 at index, index+1, -> PAYLOAD; ETX -> end-of-packet check, -> IDLE; any other byte -> o_frame_err pulse, byte treated as new ID (GET_ID rules).
REQ-019 Index 0 ≠ PKT_SUBCODE SHALL abandon the packet silently -> SKIP, no error.
REQ-020 A data byte at index ≥ PAYLOAD_LEN SHALL pulse o_frame_err and -> SKIP.
REQ-021 SKIP: DLE -> SKIP_DLE. SKIP_DLE: DLE -> SKIP; ETX -> IDLE; other -> treated as new ID (GET_ID rules), no error.
REQ-022 Payload bytes at indices 10..16 SHALL be captured into shadow registers: 10 sec, 11 min, 12 hour, 13 day, 14 month, 15 year_h, 16 year_l; bytes 0..9 are not stored beyond subcode check.
REQ-023 End-of-packet with index = PAYLOAD_LEN SHALL copy all seven shadows to outputs simultaneously and pulse o_update, both visible one clock after the ETX strobe cycle.
REQ-024 End-of-packet with index < PAYLOAD_LEN SHALL pulse o_frame_err; outputs unchanged.
REQ-025 Outputs SHALL change only on a commit; partial packets never alter them.
REQ-026 o_update and o_frame_err SHALL never assert in the same cycle.
REQ-027 Field values SHALL pass through unmodified (binary, no range check).

Reset
REQ-028 i_rst_n=0 SHALL immediately force state IDLE, index 0, shadows 8'h00, all outputs 8'h00, o_update=0, o_frame_err=0.
REQ-029 Reset mid-packet SHALL discard the packet; the next accepted packet requires a fresh DLE.
REQ-030 Reset release SHALL be synchronised internally; first active edge after release behaves as IDLE.

Verification
REQ-031 Good 8F-AB for 2024-03-15 12:34:56 -> one cycle after ETX: year_h 07, year_l E8, month 03, day 0F, hour 0C, min 22, sec 38, o_update one cycle.
REQ-032 Same packet with sec=16 sent as 10 10 -> o_thunder_seconds=8'h10, o_update pulse, no o_frame_err.
REQ-033 8F-AC packet, then 8F-AB packet with DLE bytes in TOW -> first ignored, no pulses; second commits correctly.
REQ-034 8F-AB truncated to 12 payload bytes then 10 03 -> o_frame_err pulse, outputs keep prior values.
REQ-035 i_rst_n low after 9 payload bytes, release, then full good packet -> outputs 00 during reset, then correct commit.
REQ-036 i_rx_valid gaps of 0..5 idle cycles between bytes -> results identical to back-to-back stream.
